// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit. Issues one fetch request at a time to
// instruction memory, holds the returned instruction for EXU and handles
// redirects (flush) by draining or discarding in-flight responses.
// Optional feature: define IFU_RVC_EN to allow 16-bit aligned fetch and
// report compressed instructions through ifu_o_rv32.
module ifu_fetch #(
  parameter int IR_DW   = 32,
  parameter int PC_SIZE = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_SIZE-1:0] ifu_i_pc,
  input  logic               ifu_i_flush,
  output logic               ifu_o_req_valid,
  input  logic               ifu_i_req_ready,
  output logic [PC_SIZE-1:0] ifu_o_req_addr,
  input  logic               ifu_i_rsp_valid,
  input  logic [IR_DW-1:0]   ifu_i_rsp_rdata,
  input  logic               ifu_i_rsp_err,
  output logic               ifu_o_rsp_ready,
  output logic               ifu_o_valid,
  input  logic               ifu_i_exu_ready,
  output logic [IR_DW-1:0]   ifu_o_ir,
  output logic [PC_SIZE-1:0] ifu_o_pc,
  output logic               ifu_o_rv32,
  output logic               ifu_o_bus_err,
  output logic               ifu_o_misalign
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DRAIN,
    ST_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [PC_SIZE-1:0] addr_q, addr_d;
  logic [IR_DW-1:0]   ir_q, ir_d;
  logic [PC_SIZE-1:0] pc_q, pc_d;
  logic               bus_err_q, bus_err_d;
  logic               misalign_q, misalign_d;
  logic               req_valid_q, req_valid_d;
  logic               rsp_ready_q, rsp_ready_d;

  logic               req_hs;
  logic               rsp_hs;
  logic               addr_q_mis;
  logic               addr_d_mis;

  assign req_hs = req_valid_q & ifu_i_req_ready;
  assign rsp_hs = ifu_i_rsp_valid & rsp_ready_q;

`ifdef IFU_RVC_EN
  // Compressed support: halfword alignment is enough.
  assign addr_q_mis = addr_q[0];
  assign addr_d_mis = addr_d[0];
`else
  assign addr_q_mis = |addr_q[1:0];
  assign addr_d_mis = |addr_d[1:0];
`endif

  // Next-state, next-address and held-instruction computation.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    bus_err_d  = bus_err_q;
    misalign_d = misalign_q;
    case (state_q)
      ST_IDLE: begin
        addr_d  = ifu_i_pc;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (ifu_i_flush) begin
          addr_d  = ifu_i_pc;
          state_d = req_hs ? ST_DRAIN : ST_REQ;
        end else if (addr_q_mis) begin
          ir_d       = '0;
          pc_d       = addr_q;
          bus_err_d  = 1'b0;
          misalign_d = 1'b1;
          state_d    = ST_HOLD;
        end else if (req_hs) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ifu_i_flush) begin
          addr_d  = ifu_i_pc;
          state_d = rsp_hs ? ST_REQ : ST_DRAIN;
        end else if (rsp_hs) begin
          ir_d       = ifu_i_rsp_rdata;
          pc_d       = addr_q;
          bus_err_d  = ifu_i_rsp_err;
          misalign_d = 1'b0;
          state_d    = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        if (ifu_i_flush) begin
          addr_d = ifu_i_pc;
        end
        if (rsp_hs) begin
          state_d = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (ifu_i_flush || ifu_i_exu_ready) begin
          addr_d  = ifu_i_pc;
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    req_valid_d = (state_d == ST_REQ) & ~addr_d_mis;
    rsp_ready_d = (state_d == ST_WAIT) | (state_d == ST_DRAIN);
  end

  // State, fetch address and held instruction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      ir_q        <= '0;
      pc_q        <= '0;
      bus_err_q   <= 1'b0;
      misalign_q  <= 1'b0;
      req_valid_q <= 1'b0;
      rsp_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ir_q        <= ir_d;
      pc_q        <= pc_d;
      bus_err_q   <= bus_err_d;
      misalign_q  <= misalign_d;
      req_valid_q <= req_valid_d;
      rsp_ready_q <= rsp_ready_d;
    end
  end

`ifdef IFU_RVC_EN
  logic rv32_q;
  logic rv32_d;

  assign rv32_d = (ir_d[1:0] == 2'b11);

  // Instruction length flag tracks whatever instruction is being held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv32_q <= 1'b1;
    end else begin
      rv32_q <= rv32_d;
    end
  end

  assign ifu_o_rv32 = rv32_q;
`else
  assign ifu_o_rv32 = 1'b1;
`endif

  assign ifu_o_req_valid = req_valid_q;
  assign ifu_o_req_addr  = addr_q;
  assign ifu_o_rsp_ready = rsp_ready_q;
  assign ifu_o_valid     = (state_q == ST_HOLD) & ~ifu_i_flush;
  assign ifu_o_ir        = ir_q;
  assign ifu_o_pc        = pc_q;
  assign ifu_o_bus_err   = bus_err_q;
  assign ifu_o_misalign  = misalign_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: memory responder, randomized PC/flush/EXU driver
// and a scoreboard fed by an address-level fetch model.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifu_i_pc;
  logic        ifu_i_flush;
  logic        ifu_o_req_valid;
  logic        ifu_i_req_ready;
  logic [31:0] ifu_o_req_addr;
  logic        ifu_i_rsp_valid;
  logic [31:0] ifu_i_rsp_rdata;
  logic        ifu_i_rsp_err;
  logic        ifu_o_rsp_ready;
  logic        ifu_o_valid;
  logic        ifu_i_exu_ready;
  logic [31:0] ifu_o_ir;
  logic [31:0] ifu_o_pc;
  logic        ifu_o_rv32;
  logic        ifu_o_bus_err;
  logic        ifu_o_misalign;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic        busErr;
    logic        misalign;
    logic        rv32;
  } fetch_t;

  fetch_t      expQ[$];
  logic [31:0] targetPc = '0;
  int          total = 0;
  int          bad = 0;
  int          deliveries = 0;
  int          reqCount = 0;
  int          idleCycles = 0;
  bit          memRandom = 1'b0;
  int          memLatency = 0;
  logic [31:0] corruptAddr = 32'hFFFF_FFFF;

`ifdef IFU_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  ifu_fetch #(.IR_DW(32), .PC_SIZE(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_i_pc       (ifu_i_pc),
    .ifu_i_flush    (ifu_i_flush),
    .ifu_o_req_valid(ifu_o_req_valid),
    .ifu_i_req_ready(ifu_i_req_ready),
    .ifu_o_req_addr (ifu_o_req_addr),
    .ifu_i_rsp_valid(ifu_i_rsp_valid),
    .ifu_i_rsp_rdata(ifu_i_rsp_rdata),
    .ifu_i_rsp_err  (ifu_i_rsp_err),
    .ifu_o_rsp_ready(ifu_o_rsp_ready),
    .ifu_o_valid    (ifu_o_valid),
    .ifu_i_exu_ready(ifu_i_exu_ready),
    .ifu_o_ir       (ifu_o_ir),
    .ifu_o_pc       (ifu_o_pc),
    .ifu_o_rv32     (ifu_o_rv32),
    .ifu_o_bus_err  (ifu_o_bus_err),
    .ifu_o_misalign (ifu_o_misalign)
  );

  always #5 clk = ~clk;

  // Memory contents as a pure function of the address.
  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h3C6E_F372;
  endfunction

  function automatic logic memErr(input logic [31:0] a);
    return (a[6:2] == 5'd7);
  endfunction

  function automatic logic pcMisaligned(input logic [31:0] a);
    if (RVC) return a[0];
    return (a[1:0] != 2'b00);
  endfunction

  // What EXU must eventually see for a fetch from address pc.
  function automatic fetch_t expectFor(input logic [31:0] pc);
    fetch_t e;
    e.pc = pc;
    if (pcMisaligned(pc)) begin
      e.ir       = '0;
      e.busErr   = 1'b0;
      e.misalign = 1'b1;
    end else begin
      e.ir       = memData(pc);
      e.busErr   = memErr(pc);
      e.misalign = 1'b0;
    end
    e.rv32 = RVC ? (e.ir[1:0] == 2'b11) : 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] randPc();
    logic [31:0] p;
    p = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    if ($urandom_range(0, 7) == 0) p[1:0] = 2'($urandom_range(1, 3));
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit flush, input logic [31:0] pc, input bit exuReady);
    @(posedge clk);
    #1;
    ifu_i_flush     = flush;
    ifu_i_pc        = pc;
    ifu_i_exu_ready = exuReady;
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifu_o_valid && n < 50);
    checkOutput(name, ifu_o_valid, 1);
  endtask

  task automatic waitReq(input string name, input logic [31:0] addr);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifu_o_req_valid && n < 50);
    checkOutput({name, "_valid"}, ifu_o_req_valid, 1);
    checkOutput({name, "_addr"}, ifu_o_req_addr, addr);
  endtask

  // Instruction memory: one response per accepted request, in order.
  initial begin : memory
    bit          reqHs;
    bit          rspHs;
    bit          busy;
    logic [31:0] addr;
    logic [31:0] reqAddr;
    int          delay;
    busy = 1'b0;
    addr = '0;
    delay = 0;
    ifu_i_req_ready = 1'b0;
    ifu_i_rsp_valid = 1'b0;
    ifu_i_rsp_rdata = '0;
    ifu_i_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      reqHs   = ifu_o_req_valid && ifu_i_req_ready;
      rspHs   = ifu_i_rsp_valid && ifu_o_rsp_ready;
      reqAddr = ifu_o_req_addr;
      @(posedge clk);
      #1;
      if (rst) begin
        busy = 1'b0;
        ifu_i_rsp_valid = 1'b0;
      end else begin
        if (rspHs) begin
          busy = 1'b0;
          ifu_i_rsp_valid = 1'b0;
        end
        if (reqHs) begin
          checkOutput("one_outstanding", busy, 0);
          busy  = 1'b1;
          addr  = reqAddr;
          delay = memRandom ? int'($urandom_range(0, 3)) : memLatency;
          reqCount++;
        end
        if (busy && !ifu_i_rsp_valid) begin
          if (delay == 0) begin
            ifu_i_rsp_valid = 1'b1;
            ifu_i_rsp_rdata = (addr == corruptAddr) ? 32'hDEAD_BEEF : memData(addr);
            ifu_i_rsp_err   = memErr(addr);
          end else begin
            delay--;
          end
        end
      end
      ifu_i_req_ready = memRandom ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Scoreboard monitor: pushes the expected fetch whenever the PC stage
  // redirects or EXU takes an instruction, pops on every EXU handshake.
  initial begin : monitor
    bit          wasInReset;
    bit          prevPending;
    bit          prevFlush;
    logic [31:0] prevAddr;
    fetch_t      e;
    wasInReset  = 1'b1;
    prevPending = 1'b0;
    prevFlush   = 1'b0;
    prevAddr    = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        wasInReset  = 1'b1;
        prevPending = 1'b0;
        expQ.delete();
      end else begin
        if (wasInReset) begin
          wasInReset = 1'b0;
          idleCycles = 0;
          targetPc   = ifu_i_pc;
          expQ.push_back(expectFor(ifu_i_pc));
        end
        if (prevPending && !prevFlush) begin
          checkOutput("req_valid_held", ifu_o_req_valid, 1);
          checkOutput("req_addr_held", ifu_o_req_addr, prevAddr);
        end
        if (ifu_o_req_valid && ifu_i_req_ready && !ifu_i_flush)
          checkOutput("req_addr", ifu_o_req_addr, targetPc);
        if (ifu_i_flush) begin
          checkOutput("valid_squashed_by_flush", ifu_o_valid, 0);
          expQ.delete();
          targetPc = ifu_i_pc;
          expQ.push_back(expectFor(ifu_i_pc));
        end else if (ifu_o_valid && ifu_i_exu_ready) begin
          checkOutput("scoreboard_nonempty", expQ.size() != 0, 1);
          if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput("deliver_ir", ifu_o_ir, e.ir);
            checkOutput("deliver_pc", ifu_o_pc, e.pc);
            checkOutput("deliver_bus_err", ifu_o_bus_err, e.busErr);
            checkOutput("deliver_misalign", ifu_o_misalign, e.misalign);
            checkOutput("deliver_rv32", ifu_o_rv32, e.rv32);
          end
          deliveries++;
          idleCycles = 0;
          targetPc = ifu_i_pc;
          expQ.push_back(expectFor(ifu_i_pc));
        end else begin
          idleCycles++;
        end
        if (idleCycles > 150) begin
          checkOutput("delivery_progress", 0, 1);
          idleCycles = 0;
        end
        prevPending = ifu_o_req_valid && !ifu_i_req_ready;
        prevFlush   = ifu_i_flush;
        prevAddr    = ifu_o_req_addr;
      end
    end
  end

  // Main sequence: reset, directed scenarios, then randomized traffic.
  initial begin : stimulus
    int          snap;
    logic [31:0] misPc;
    rst             = 1'b1;
    ifu_i_pc        = 32'h0;
    ifu_i_flush     = 1'b0;
    ifu_i_exu_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", ifu_o_valid, 0);
    checkOutput("rst_req_valid", ifu_o_req_valid, 0);
    checkOutput("rst_rsp_ready", ifu_o_rsp_ready, 0);
    checkOutput("rst_rv32", ifu_o_rv32, 1);
    checkOutput("rst_ir", ifu_o_ir, 0);
    checkOutput("rst_pc", ifu_o_pc, 0);
    checkOutput("rst_bus_err", ifu_o_bus_err, 0);
    checkOutput("rst_misalign", ifu_o_misalign, 0);
    #1;
    rst = 1'b0;

    // First fetch from 0 with single-cycle memory.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("valid_not_before_3", ifu_o_valid, 0);
    @(posedge clk);
    #1;
    checkOutput("valid_after_3", ifu_o_valid, 1);
    checkOutput("first_ir", ifu_o_ir, 32'h0000_0013);
    checkOutput("first_pc", ifu_o_pc, 32'h0);
    checkOutput("first_rv32", ifu_o_rv32, 1);

    // EXU stalls for five cycles; the held instruction must not move.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_valid", ifu_o_valid, 1);
      checkOutput("hold_ir_stable", ifu_o_ir, 32'h0000_0013);
    end
    memLatency  = 3;
    corruptAddr = 32'h4;
    applyStimulus(0, 32'h4, 1);
    applyStimulus(0, 32'h4, 0);
    waitReq("next_req", 32'h4);

    // Redirect while waiting; the stale response must be discarded.
    applyStimulus(1, 32'h80, 0);
    applyStimulus(0, 32'h80, 0);
    waitReq("req_after_flush", 32'h80);
    waitValid("valid_after_flush");
    checkOutput("stale_discarded", ifu_o_ir == 32'hDEAD_BEEF, 0);
    checkOutput("ir_after_flush", ifu_o_ir, memData(32'h80));
    memLatency  = 0;
    corruptAddr = 32'hFFFF_FFFF;

    // Address 0x102: halfword aligned only.
    misPc = 32'h102;
    applyStimulus(1, misPc, 0);
    snap = reqCount;
    applyStimulus(0, misPc, 0);
    repeat (10) @(negedge clk);
    checkOutput("req_count_0x102", reqCount - snap, RVC ? 1 : 0);
    checkOutput("valid_0x102", ifu_o_valid, 1);
    checkOutput("misalign_0x102", ifu_o_misalign, RVC ? 0 : 1);

    // Bus error is reported with the data, and cleared by the next fetch.
    applyStimulus(1, 32'h1C, 0);
    applyStimulus(0, 32'h1C, 0);
    waitValid("valid_bus_err");
    checkOutput("bus_err_set", ifu_o_bus_err, 1);
    checkOutput("bus_err_ir", ifu_o_ir, memData(32'h1C));
    applyStimulus(1, 32'h20, 0);
    applyStimulus(0, 32'h20, 0);
    waitValid("valid_after_err");
    checkOutput("bus_err_cleared", ifu_o_bus_err, 0);

    // Randomized PC stage / EXU / memory traffic.
    memRandom = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 9) == 0, randPc(), $urandom_range(0, 1) == 1);
    end
    applyStimulus(0, 32'h0, 0);
    repeat (5) @(negedge clk);
    checkOutput("deliveries_seen", deliveries > 30, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter: IR_DW, default 32, instruction register width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 ifu_i_pc  input  PC_SIZE  next fetch address from the PC stage (its pcnxt output).
REQ-005 ifu_i_flush  input  1  redirect: squash the held or in-flight fetch and refetch from ifu_i_pc.
REQ-006 ifu_o_req_valid / ifu_i_req_ready / ifu_o_req_addr[PC_SIZE]: fetch-request handshake to instruction memory.
REQ-007 ifu_i_rsp_valid / ifu_i_rsp_rdata[31:0] / ifu_i_rsp_err / ifu_o_rsp_ready: fetch-response handshake; one response per accepted request, in order.
REQ-008 ifu_o_valid  output  1  instruction available to EXU (feeds the PC stage ifu_valid input).
REQ-009 ifu_i_exu_ready  input  1  EXU accepts the instruction.
REQ-010 ifu_o_ir[31:0], ifu_o_pc[PC_SIZE], ifu_o_rv32, ifu_o_bus_err, ifu_o_misalign: the held instruction and its attributes.

Function
REQ-011 FSM states: IDLE, REQ, WAIT, DRAIN, HOLD; handshake = valid & ready in the same cycle.
REQ-012 IDLE: after reset release, one cycle in IDLE, then REQ with addr_q = ifu_i_pc.
REQ-013 REQ: ifu_o_req_valid = 1 and ifu_o_req_addr = addr_q; on request handshake, go to WAIT.
REQ-014 REQ with addr_q misaligned: no request is issued; go to HOLD with ifu_o_misalign = 1, ifu_o_ir = 0, ifu_o_pc = addr_q.
REQ-015 WAIT: ifu_o_rsp_ready = 1; on response handshake, set IR = rdata, ifu_o_pc = addr_q, ifu_o_bus_err = rsp_err, and go to HOLD.
REQ-016 HOLD: ifu_o_valid = (state == HOLD) & ~ifu_i_flush, combinational; the held values are stable until handshake.
REQ-017 HOLD on EXU handshake: addr_q samples ifu_i_pc and the FSM goes to REQ; fetch-to-fetch minimum is 3 cycles (REQ, WAIT, HOLD) with 1-cycle memory.
REQ-018 Flush in REQ without a request handshake: addr_q reloads from ifu_i_pc and the FSM stays in REQ.
REQ-019 Flush in REQ with a request handshake in the same cycle: addr_q reloads and the FSM goes to DRAIN.
REQ-020 Flush in WAIT without a response: go to DRAIN with addr_q reloaded.
REQ-021 Flush in WAIT with a response in the same cycle: the response is discarded, addr_q reloads, and the FSM goes to REQ.
REQ-022 DRAIN: ifu_o_rsp_ready = 1; the response is discarded and the FSM goes to REQ; a flush during DRAIN only reloads addr_q.
REQ-023 Flush in HOLD: the instruction is squashed and no EXU handshake occurs even if exu_ready = 1; addr_q reloads and the FSM goes to REQ.
REQ-024 ifu_o_rsp_ready is 0 outside WAIT/DRAIN, and ifu_o_req_valid is 0 outside REQ.
REQ-025 The block has at most one outstanding request.
REQ-026 A response while not in WAIT/DRAIN is ignored.
REQ-027 ifu_o_req_valid, once asserted, is held until handshake or flush.

Reset
REQ-028 On rst, asynchronously: state = IDLE; addr_q = 0; ifu_o_ir = 0; ifu_o_pc = 0; ifu_o_bus_err = 0; ifu_o_misalign = 0.
REQ-029 On rst, asynchronously: ifu_o_req_valid, ifu_o_rsp_ready and ifu_o_valid = 0; ifu_o_rv32 = 1.
REQ-030 Reset mid-transaction abandons the outstanding request; the memory side is reset by the same rst.

Configuration
REQ-031 Macro IFU_RVC_EN defined: ifu_o_rv32 = (IR[1:0] == 2'b11); misaligned means addr_q[0] = 1.
REQ-032 IFU_RVC_EN undefined: ifu_o_rv32 is constant 1; misaligned means addr_q[1:0] != 0.

Verification
REQ-033 Reset, pc = 0x0, req_ready = 1, rsp 1 cycle later with rdata = 0x00000013: ifu_o_valid high 3 cycles after reset release, ir = 0x00000013, pc = 0x0, rv32 = 1.
REQ-034 HOLD with exu_ready = 0 for 5 cycles, then 1 with ifu_i_pc = 0x4: ir stable for 5 cycles; the next req_addr = 0x4.
REQ-035 Flush with ifu_i_pc = 0x80 in WAIT, then stale rsp 0xDEADBEEF: it is discarded; the next request has addr 0x80; ifu_o_valid never shows 0xDEADBEEF.
REQ-036 Flush and exu_ready both high in HOLD: ifu_o_valid = 0 that cycle; the next req_addr = the flush pc.
REQ-037 With IFU_RVC_EN and pc = 0x102, rdata[1:0] = 2'b01: request issued, rv32 = 0; without IFU_RVC_EN, pc = 0x102 gives misalign = 1 and no request.
REQ-038 rsp_err = 1 with rdata = 0x12345678: HOLD with bus_err = 1, ir = 0x12345678; flush clears it and a new request issues.
